serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor, one full-subtractor cell per cycle, LSB first.
// Computes {borrow_out, diff} = a - b - borrow_in (mod 2^(WIDTH+1)).
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - synchronous active-high reset
//   start      - begin a subtraction (sampled only in IDLE)
//   a, b       - minuend / subtrahend (WIDTH bits)
//   borrow_in  - initial borrow into bit 0
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when a new result is valid
//   diff       - registered difference (WIDTH bits)
//   borrow_out - registered final borrow
//   result     - {borrow_out, diff}
module serial_subtractor #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [WIDTH:0]   result
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic             bor_q;
    logic             last_bit;
    logic             d_bit;
    logic             bor_nxt;
    logic             busy_d;
    logic             done_d;

    // Full-subtractor cell on the current LSBs
    assign d_bit    = a_q[0] ^ b_q[0] ^ bor_q;
    assign bor_nxt  = (~a_q[0] & b_q[0]) | (~a_q[0] & bor_q) | (b_q[0] & bor_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so busy/done are registered alongside it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            SHIFT:   busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            bor_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        bor_q <= borrow_in;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sh_q  <= {d_bit, sh_q[WIDTH-1:1]};
                    bor_q <= bor_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    // Final bit: publish the complete word, never partial bits
                    if (last_bit) begin
                        diff       <= {d_bit, sh_q[WIDTH-1:1]};
                        borrow_out <= bor_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = {borrow_out, diff};

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=5): scoreboard queue filled at
// stimulus time, drained by a monitor whenever done pulses.
module tb_serial_subtractor;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic [W:0]   result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_done = -1;
    bit per_chk = 1'b0;
    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {borrow, diff} is the difference modulo 2^(W+1)
    function automatic logic [W:0] model(input int av, input int bv, input int bi);
        int r;
        r = av - bv - bi;
        return (W+1)'(r & ((1 << (W+1)) - 1));
    endfunction

    // Monitor: drain scoreboard on each done pulse
    always @(negedge clk) begin
        logic [W:0] e;
        if (busy && done) chk("busy_done_overlap", 1, 0);
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("diff", int'(diff), int'(e[W-1:0]));
                chk("borrow_out", int'(borrow_out), int'(e[W]));
                chk("result", int'(result), int'(e));
            end
            if (per_chk && last_done >= 0) chk("done_period", cyc - last_done, W + 2);
            last_done = cyc;
        end
    end

    // Wait (bounded) until the negedge at which done is seen; counts busy cycles
    task automatic wait_done(input bit glitch, output int busy_cnt);
        int n;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (glitch && n == 1) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end
            if (glitch && n == 2) start = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int av, input int bv, input int bi, input bit glitch);
        int bc;
        @(negedge clk);
        a = W'(av); b = W'(bv); borrow_in = bi[0]; start = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after the load edge; must not disturb the operation
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        wait_done(glitch, bc);
        chk("busy_cycles", bc, W);
    endtask

    initial begin
        int bc;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        reset = 1'b0;

        // Directed vectors
        run_op(5'b10101, 5'b01010, 0, 1'b0);
        run_op(5'b00011, 5'b01010, 0, 1'b0);
        run_op(5'b00100, 5'b01011, 0, 1'b0);
        run_op(5'b00000, 5'b00000, 1, 1'b0);
        run_op(5'b11111, 5'b11111, 0, 1'b0);
        // Start pulse and operand changes during SHIFT are ignored
        run_op(5'b10011, 5'b00110, 1, 1'b1);
        repeat (12) @(negedge clk);

        // Reset in the third SHIFT cycle aborts with no done and cleared outputs
        a = 5'b01001; b = 5'b10110; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_borrow", int'(borrow_out), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        run_op(5'b01001, 5'b10110, 0, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 1)), 1'b0);

        // Exhaustive sweep with start held high: one result every W+2 cycles
        @(negedge clk);
        per_chk = 1'b1;
        last_done = -1;
        start = 1'b1;
        for (int av = 0; av < 32; av++)
            for (int bv = 0; bv < 32; bv++)
                for (int bi = 0; bi < 2; bi++) begin
                    a = W'(av); b = W'(bv); borrow_in = bi[0];
                    exp_q.push_back(model(av, bv, bi));
                    @(negedge clk);
                    wait_done(1'b0, bc);
                    if (!done) begin
                        $display("FAIL sweep_stall: got no done expected done");
                        $fatal(1, "sweep stalled");
                    end
                end
        start = 1'b0;
        repeat (12) @(negedge clk);
        per_chk = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
